// File: rtl/ahb_fifo_slave.sv
// AHB-Lite slave exposing a DEPTH-word FIFO with status/ctrl/threshold registers and a level IRQ.
// Zero-wait OKAY transfers; protocol errors answer with a two-cycle ERROR (HREADYOUT low in cycle 1).
module ahb_fifo_slave #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [11:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        IRQ
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_THR  = 2'd3;

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx, level;
  logic          irq_en;
  logic          dp_vld, dp_write;
  logic [1:0]    dp_addr;

  logic accept, new_err, full, empty, full_nx, empty_nx;
  logic do_push, do_pop, do_ctrl, do_clear, do_thr;
  logic unused_bits;

  assign unused_bits = ^{HADDR[11:4], HADDR[1:0], HTRANS[0]};

  // dp_vld only ever marks an OKAY data phase; errored transfers never act on state.
  assign do_push  = dp_vld &  dp_write & (dp_addr == A_DATA);
  assign do_pop   = dp_vld & ~dp_write & (dp_addr == A_DATA);
  assign do_ctrl  = dp_vld &  dp_write & (dp_addr == A_CTRL);
  assign do_thr   = dp_vld &  dp_write & (dp_addr == A_THR);
  assign do_clear = do_ctrl & HWDATA[0];

  always_comb begin
    count_nx = count;
    if (do_clear)     count_nx = '0;
    else if (do_push) count_nx = count + CW'(1);
    else if (do_pop)  count_nx = count - CW'(1);
  end

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign full_nx  = (count_nx == CW'(DEPTH));
  assign empty_nx = (count_nx == '0);

  // The new address phase is judged against the count as left by the data phase ending now.
  assign accept  = HSEL & HREADY & HTRANS[1] & (state != ERR1);
  assign new_err = (HSIZE != 3'b010)
                 | ( HWRITE & (HADDR[3:2] == A_STAT))
                 | ( HWRITE & (HADDR[3:2] == A_DATA) & full_nx)
                 | (~HWRITE & (HADDR[3:2] == A_DATA) & empty_nx);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      dp_vld    <= 1'b0;
      dp_write  <= 1'b0;
      dp_addr   <= 2'd0;
    end else begin
      dp_vld <= 1'b0;
      case (state)
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          if (accept && new_err) begin
            state     <= ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            if (accept) begin
              dp_vld   <= 1'b1;
              dp_write <= HWRITE;
              dp_addr  <= HADDR[3:2];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      irq_en <= 1'b0;
      level  <= '0;
      IRQ    <= 1'b0;
    end else begin
      count <= count_nx;
      if (do_clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_ctrl) irq_en <= HWDATA[1];
      if (do_thr)  level  <= HWDATA[CW-1:0];
      IRQ <= irq_en & (count >= level) & (level != '0);
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= HWDATA;
  end

  always_comb begin
    HRDATA = '0;
    if (dp_vld && !dp_write) begin
      case (dp_addr)
        A_DATA:  HRDATA = mem[rd_ptr];
        A_STAT:  HRDATA = {14'b0, full, empty, {(16-CW){1'b0}}, count};
        A_CTRL:  HRDATA = {30'b0, irq_en, 1'b0};
        default: HRDATA = {{(32-CW){1'b0}}, level};
      endcase
    end
  end

endmodule

// File: doc/ahb_fifo_slave.md
AHB_FIFO_SLAVE -- requirements
Module: ahb_fifo_slave

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries, a power of two from 2 to 64.
REQ-002 The block SHALL have parameter CW, default clog2(DEPTH)+1, meaning count width.
REQ-003 The block SHALL have the port HCLK  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port HRESET  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have the port HSEL  input  1  slave select.
REQ-006 The block SHALL have the port HADDR  input  12  byte address; bits [3:2] decode the register.
REQ-007 The block SHALL have the ports HTRANS  input  2, HSIZE  input  3, HWRITE  input  1: AHB-Lite transfer type, size and direction.
REQ-008 The block SHALL have the port HWDATA  input  32  write data, valid in the data phase.
REQ-009 The block SHALL have the port HREADY  input  1  bus ready.
REQ-010 The block SHALL have the ports HREADYOUT  output  1, HRDATA  output  32, HRESP  output  1: slave response.
REQ-011 The block SHALL have the port IRQ  output  1  level interrupt.

Function
REQ-012 The block SHALL accept a transfer only when HSEL & HREADY & HTRANS[1] are high at a rising edge. It SHALL register HADDR[3:2], HWRITE and HSIZE for the data phase.
REQ-013 The register map SHALL be:
- 0x0 DATA: a write pushes, a read pops.
- 0x4 STATUS (read-only): [CW-1:0] = count, [16] = empty, [17] = full.
- 0x8 CTRL: [0] = clear (write-1, self-clearing), [1] = irq_en.
- 0xC THRESH: [CW-1:0] = level.
REQ-014 A valid OKAY transfer SHALL complete in one data-phase cycle with zero wait states and HRESP = 0.
REQ-015 A DATA write SHALL store HWDATA at the tail at the end of the data phase. The push SHALL then increment the count and advance the write pointer modulo DEPTH.
REQ-016 A DATA read SHALL drive the head entry on HRDATA during the data phase. The pop SHALL then decrement the count and advance the read pointer modulo DEPTH at the end of that cycle.
REQ-017 Back-to-back pipelined transfers SHALL observe every prior data-phase update: a DATA read immediately following a DATA write to an empty FIFO SHALL return that written word.
REQ-018 The following SHALL produce a two-cycle ERROR response with no state change:
- a DATA write when full;
- a DATA read when empty;
- any transfer with HSIZE != 3'b010;
- a write to STATUS.
REQ-019 The ERROR response sequence SHALL be:
- cycle 1: HREADYOUT = 0, HRESP = 1;
- cycle 2: HREADYOUT = 1, HRESP = 1.
REQ-020 Transfers presented during ERROR cycle 1 SHALL be ignored, because HREADY is low.
REQ-021 The response logic SHALL be a three-state FSM.
- States: IDLE, ERR1, ERR2.
- IDLE -> ERR1 on an error-qualified transfer; otherwise the FSM stays in IDLE.
- ERR1 -> ERR2 unconditionally.
- ERR2 -> IDLE, or ERR2 -> ERR1 if the new address phase accepted in ERR2 is erroneous. Its error is evaluated in its own data phase.
REQ-022 A CTRL write with bit 0 set SHALL zero the pointers and count at the end of the data phase. Clear SHALL take priority over nothing else pending, since only one transfer is in data phase.
REQ-023 Count SHALL saturate logically: push is never executed at DEPTH and pop is never executed at 0 (see REQ-018).
REQ-024 Reads of CTRL SHALL return {30'b0, irq_en, 1'b0}. Reads of THRESH SHALL return the zero-extended level.
REQ-025 HRDATA SHALL be 0 in any cycle without an OKAY read data phase.
REQ-026 IRQ SHALL be the registered value of irq_en & (count >= level) & (level != 0), updated one cycle after the count changes.
REQ-027 Unselected or IDLE/BUSY transfers SHALL return OKAY with HREADYOUT = 1 and no state change.

Reset
REQ-028 While HRESET is high, the block SHALL asynchronously force the following:
- pointers = 0, count = 0, irq_en = 0, level = 0;
- FSM = IDLE, HREADYOUT = 1, HRESP = 0, HRDATA = 0, IRQ = 0.
REQ-029 Reset asserted mid-transfer, including during ERR1, SHALL abandon the transfer. The FIFO SHALL be empty afterwards; stored data contents are don't-care.
REQ-030 The first transfer SHALL be accepted at the first rising edge after HRESET deasserts.

Verification
REQ-031 Bench scenario: write 0x11,0x22,0x33 to DATA, then read DATA three times -> reads return 0x11,0x22,0x33, all OKAY, zero wait; STATUS then reads 0x0001_0000.
REQ-032 Bench scenario: DEPTH=8; push 8 words, then a 9th -> the 9th gets ERROR with HREADYOUT 0/1 over two cycles; STATUS reads 0x0002_0008; the FIFO contents are unchanged.
REQ-033 Bench scenario: read DATA when empty -> ERROR; a pipelined DATA write accepted in ERR2 -> OKAY; the following read returns that word.
REQ-034 Bench scenario: THRESH=3, CTRL=0x2, push 3 words -> IRQ rises one cycle after the third push; one pop -> IRQ falls.
REQ-035 Bench scenario: 5 words pushed with wrap (after 6 push/pop cycles), then CTRL=0x1 -> STATUS reads 0x0001_0000; a subsequent read of DATA returns ERROR.
REQ-036 Bench scenario: assert HRESET during ERR1 -> HREADYOUT=1, HRESP=0 immediately; count=0, IRQ=0.
